nvram_uploader: RTL and testbench
=================================

NVRAM_UPLOADER -- requirements
Module: nvram_uploader

Interface
REQ-001 Parameter CMOS_AW, default 10: CMOS address width (1024 nibble locations).
REQ-002 Parameter QUIET_FRAMES, default 60: write-free frames required before an auto-save request.
REQ-003 clock_12  in  1  system clock; all logic runs on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 save_en  in  1  auto-save enable (OSD bit).
REQ-006 upload  in  1  HPS upload session active, already qualified by NVRAM ioctl_index.
REQ-007 rd  in  1  HPS read strobe (one cycle per byte).
REQ-008 addr  in  25  HPS byte address for the current read.
REQ-009 din  out  8  byte returned to HPS.
REQ-010 upload_req  out  1  one-cycle pulse requesting an HPS upload.
REQ-011 cmos_we  in  1  game CPU wrote CMOS this cycle.
REQ-012 vblank  in  1  video vertical blank, used as the frame tick.
REQ-013 ram_addr  out  CMOS_AW  CMOS second-port read address.
REQ-014 ram_rd  out  1  CMOS second-port read enable.
REQ-015 ram_q  in  4  CMOS nibble, valid one cycle after ram_rd.
REQ-016 busy  out  1  a fetch is in progress.

Function
REQ-017 The read FSM shall have states IDLE, FETCH, WAIT and HOLD.
REQ-018 In IDLE, rd=1 with upload=1 shall latch addr and move to FETCH on the next cycle.
REQ-019 In FETCH: if addr < 2^CMOS_AW, assert ram_rd for one cycle with ram_addr=addr[CMOS_AW-1:0] and go to WAIT; otherwise load din=8'hFF and go to HOLD.
REQ-020 In WAIT, register din={4'hF, ram_q} and go to HOLD.
REQ-021 din shall become valid no more than 3 cycles after rd and shall hold stable until the next accepted rd.
REQ-022 HOLD shall return to IDLE in one cycle; busy=1 in FETCH and WAIT only.
REQ-023 An rd that arrives while busy=1 shall be ignored.
REQ-024 An rd with upload=0 shall be ignored.
REQ-025 Deassertion of upload in any state shall return the FSM to IDLE next cycle, with din kept.
REQ-026 A frame tick shall be a registered rising edge of vblank.
REQ-027 cmos_we shall set a dirty flag and clear a frame counter of width clog2(QUIET_FRAMES+1).
REQ-028 While dirty=1 and cmos_we=0, each frame tick shall increment the counter, saturating at QUIET_FRAMES.
REQ-029 When dirty=1, save_en=1, upload=0, the counter equals QUIET_FRAMES and no request is pending, upload_req shall pulse for exactly one cycle and set the pending flag.
REQ-030 A falling edge of upload shall clear the pending flag; it shall also clear dirty unless cmos_we occurred at any time during that session.
REQ-031 cmos_we coincident with a frame tick: the clear takes priority and the counter goes to 0.
REQ-032 save_en=0 shall suppress upload_req only; dirty and counter tracking continue.
REQ-033 A manual upload (upload rising with no pending request) shall be served identically.

Reset
REQ-034 With reset_n=0 at a clock edge, the block shall enter: FSM=IDLE, din=8'h00, ram_rd=0, ram_addr=0, busy=0, upload_req=0, dirty=0, pending=0, counter=0, vblank edge register=0.
REQ-035 Reset during FETCH or WAIT shall discard the fetch; ram_rd shall be 0 on the cycle after reset.

Structure
REQ-036 The shared williams2 package shall hold CMOS_AW, the pad nibble 4'hF, the out-of-range byte 8'hFF and the FSM state enum.
REQ-037 The dirty/quiet-frame request logic shall be a sub-module named nvram_save_timer; the read FSM stays in nvram_uploader.

Verification
REQ-038 With CMOS[0x005]=4'hA, upload=1 and rd at addr=5: ram_rd pulses once with ram_addr=5, and din=8'hFA within 3 cycles and held.
REQ-039 With upload=1, rd at addr=1024: no ram_rd occurs and din=8'hFF.
REQ-040 With QUIET_FRAMES=3, save_en=1 and one cmos_we followed by 3 vblank pulses: exactly one upload_req pulse, on the cycle after the third tick is counted; none after further ticks.
REQ-041 cmos_we on the 2nd tick, then 3 quiet ticks: upload_req fires only after the last quiet tick; with save_en=0, no pulse fires.
REQ-042 cmos_we during an upload session, then upload falls: dirty remains 1 and a new upload_req fires after QUIET_FRAMES ticks.
REQ-043 reset_n=0 during WAIT: all outputs take reset values next cycle, and a subsequent rd is served normally.

Source files
------------

// File: rtl/williams2_pkg.sv
// Shared williams2 definitions used by the NVRAM upload path.
//   CMOS_AW    : default CMOS address width (1024 nibble locations)
//   PAD_NIBBLE : upper nibble returned alongside each CMOS nibble
//   OOR_BYTE   : byte returned for addresses beyond the CMOS
//   upl_state_t: read FSM states
package williams2_pkg;

    localparam int         CMOS_AW    = 10;
    localparam logic [3:0] PAD_NIBBLE = 4'hF;
    localparam logic [7:0] OOR_BYTE   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } upl_state_t;

endpackage

// File: rtl/nvram_save_timer.sv
// Auto-save request generator. Tracks CMOS writes from the game CPU and,
// once the CMOS has been quiet for QUIET_FRAMES frames, pulses upload_req
// for one cycle so the HPS fetches a fresh NVRAM image.
//   clock_12   in  system clock
//   reset_n    in  synchronous active-low reset
//   save_en    in  auto-save enable
//   upload     in  HPS upload session active
//   cmos_we    in  game CPU wrote CMOS this cycle
//   vblank     in  vertical blank, rising edge is the frame tick
//   upload_req out one-cycle upload request pulse
module nvram_save_timer #(
    parameter int QUIET_FRAMES = 60
) (
    input  logic clock_12,
    input  logic reset_n,
    input  logic save_en,
    input  logic upload,
    input  logic cmos_we,
    input  logic vblank,
    output logic upload_req
);

    localparam int             CW = $clog2(QUIET_FRAMES + 1);
    localparam logic [CW-1:0]  QF = CW'(QUIET_FRAMES);

    logic          vblank_q;
    logic          upload_q;
    logic          dirty;
    logic          pending;
    logic          sess_we;   // CPU wrote CMOS during the current upload session
    logic [CW-1:0] cnt;

    logic tick, upl_rise, upl_fall, req_fire;

    assign tick     = vblank & ~vblank_q;
    assign upl_rise = upload & ~upload_q;
    assign upl_fall = ~upload & upload_q;
    assign req_fire = dirty & save_en & ~upload & (cnt == QF) & ~pending;

    always_ff @(posedge clock_12) begin
        if (!reset_n) begin
            vblank_q   <= 1'b0;
            upload_q   <= 1'b0;
            dirty      <= 1'b0;
            pending    <= 1'b0;
            sess_we    <= 1'b0;
            cnt        <= '0;
            upload_req <= 1'b0;
        end else begin
            vblank_q   <= vblank;
            upload_q   <= upload;
            upload_req <= req_fire;

            // A write restarts the quiet period even on a tick cycle.
            if (cmos_we) begin
                dirty <= 1'b1;
                cnt   <= '0;
            end else if (tick && dirty && cnt != QF) begin
                cnt <= cnt + 1'b1;
            end

            if (upl_rise)
                sess_we <= cmos_we;
            else if (upload && cmos_we)
                sess_we <= 1'b1;

            // The finished session captured the CMOS only if nothing was
            // written while it ran; otherwise stay dirty for another save.
            if (upl_fall) begin
                pending <= 1'b0;
                if (!sess_we && !cmos_we)
                    dirty <= 1'b0;
            end else if (req_fire) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/nvram_uploader.sv
// Serves HPS NVRAM upload reads from the CMOS second port. Each byte read
// returns {4'hF, nibble}; addresses beyond the CMOS return 8'hFF. Also
// hosts the auto-save timer that requests uploads after CMOS activity.
//   clock_12   in  system clock
//   reset_n    in  synchronous active-low reset
//   save_en    in  auto-save enable
//   upload     in  HPS upload session active
//   rd, addr   in  HPS byte read strobe and address
//   din        out byte returned to HPS (held until next accepted rd)
//   upload_req out one-cycle upload request
//   cmos_we    in  game CPU CMOS write
//   vblank     in  frame tick source
//   ram_addr, ram_rd out / ram_q in : CMOS second port (1-cycle latency)
//   busy       out fetch in progress
module nvram_uploader #(
    parameter int CMOS_AW      = williams2_pkg::CMOS_AW,
    parameter int QUIET_FRAMES = 60
) (
    input  logic               clock_12,
    input  logic               reset_n,
    input  logic               save_en,
    input  logic               upload,
    input  logic               rd,
    input  logic [24:0]        addr,
    output logic [7:0]         din,
    output logic               upload_req,
    input  logic               cmos_we,
    input  logic               vblank,
    output logic [CMOS_AW-1:0] ram_addr,
    output logic               ram_rd,
    input  logic [3:0]         ram_q,
    output logic               busy
);

    import williams2_pkg::*;

    upl_state_t state;
    logic       oor_q;   // latched address lies beyond the CMOS
    logic       in_rng;

    assign in_rng = ((addr >> CMOS_AW) == 25'd0);

    // ram_rd is raised on entry to FETCH so the nibble is on ram_q
    // during WAIT, giving din three cycles after rd.
    always_ff @(posedge clock_12) begin
        if (!reset_n) begin
            state    <= IDLE;
            din      <= 8'h00;
            ram_rd   <= 1'b0;
            ram_addr <= '0;
            busy     <= 1'b0;
            oor_q    <= 1'b0;
        end else if (!upload) begin
            state  <= IDLE;
            ram_rd <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rd) begin
                    ram_addr <= addr[CMOS_AW-1:0];
                    ram_rd   <= in_rng;
                    oor_q    <= ~in_rng;
                    busy     <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    ram_rd <= 1'b0;
                    if (oor_q) begin
                        din   <= OOR_BYTE;
                        busy  <= 1'b0;
                        state <= HOLD;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    din   <= {PAD_NIBBLE, ram_q};
                    busy  <= 1'b0;
                    state <= HOLD;
                end
                HOLD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    nvram_save_timer #(.QUIET_FRAMES(QUIET_FRAMES)) u_save_timer (
        .clock_12   (clock_12),
        .reset_n    (reset_n),
        .save_en    (save_en),
        .upload     (upload),
        .cmos_we    (cmos_we),
        .vblank     (vblank),
        .upload_req (upload_req)
    );

endmodule

// File: tb/tb_nvram_uploader.sv
// Scoreboard bench: stimulus pushes expected din bytes, CMOS read
// addresses and upload_req cycles; a negedge monitor pops and compares.
module tb_nvram_uploader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        save_en = 1'b1;
    logic        upload = 1'b0;
    logic        rd = 1'b0;
    logic [24:0] addr = '0;
    logic [7:0]  din;
    logic        upload_req;
    logic        cmos_we = 1'b0;
    logic        vblank = 1'b0;
    logic [9:0]  ram_addr;
    logic        ram_rd;
    logic [3:0]  ram_q = 4'h0;
    logic        busy;

    nvram_uploader #(.CMOS_AW(10), .QUIET_FRAMES(3)) dut (
        .clock_12(clk), .reset_n(reset_n), .save_en(save_en), .upload(upload),
        .rd(rd), .addr(addr), .din(din), .upload_req(upload_req),
        .cmos_we(cmos_we), .vblank(vblank), .ram_addr(ram_addr),
        .ram_rd(ram_rd), .ram_q(ram_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // CMOS model, one-cycle read latency
    logic [3:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 4'(i);
        mem[5]     = 4'hA;
        mem[7]     = 4'h6;
        mem[10'h3FF] = 4'h3;
    end
    always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    logic abort = 1'b0;
    logic busy_prev = 1'b0;

    int din_q[$];
    int ram_q_exp[$];
    int req_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm, input int act);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event, got %0h expected none", nm, act);
    endtask

    always @(negedge clk) begin
        busy_prev <= busy;
        if (!abort && reset_n) begin
            if (busy_prev && !busy) begin
                if (din_q.size() == 0) unexp("din_unexp", din);
                else chk("din", din, din_q.pop_front());
            end
            if (ram_rd) begin
                if (ram_q_exp.size() == 0) unexp("ram_rd_unexp", ram_addr);
                else chk("ram_addr", ram_addr, ram_q_exp.pop_front());
            end
        end
        if (upload_req) begin
            if (req_q.size() == 0) unexp("upload_req_unexp", cyc);
            else chk("upload_req_cycle", cyc, req_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [24:0] a, input logic [7:0] e);
        din_q.push_back(e);
        if (a < 25'd1024) ram_q_exp.push_back(int'(a));
        rd = 1'b1; addr = a;
        step();
        rd = 1'b0;
        repeat (4) step();
    endtask

    task automatic tick(input logic we, input logic expect_req);
        vblank = 1'b1; cmos_we = we;
        if (expect_req) req_q.push_back(cyc + 2);
        step();
        vblank = 1'b0; cmos_we = 1'b0;
        repeat (3) step();
    endtask

    task automatic we_pulse();
        cmos_we = 1'b1; step(); cmos_we = 1'b0; step();
    endtask

    task automatic session();
        upload = 1'b1; step(); step();
        upload = 1'b0; step(); step();
    endtask

    initial begin
        // reset state
        repeat (2) step();
        chk("rst_din", din, 8'h00);
        chk("rst_ram_rd", ram_rd, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_upload_req", upload_req, 0);
        reset_n = 1'b1;
        step();

        // reads
        upload = 1'b1; step();
        do_read(25'd5, 8'hFA);
        do_read(25'h3FF, 8'hF3);
        do_read(25'd1024, 8'hFF);
        do_read(25'h1FFFFFF, 8'hFF);

        // second rd while busy is ignored
        din_q.push_back(8'hF6); ram_q_exp.push_back(7);
        rd = 1'b1; addr = 25'd7; step();
        rd = 1'b1; addr = 25'd5; step();
        rd = 1'b0; repeat (3) step();
        repeat (3) step();
        chk("din_hold", din, 8'hF6);

        // upload drops mid-fetch: back to IDLE, din kept
        abort = 1'b1;
        rd = 1'b1; addr = 25'd5; step();
        rd = 1'b0; upload = 1'b0; step();
        chk("drop_busy", busy, 0);
        chk("drop_ram_rd", ram_rd, 0);
        chk("drop_din", din, 8'hF6);
        step(); abort = 1'b0; step();

        // rd with upload low ignored
        rd = 1'b1; addr = 25'd5; step();
        rd = 1'b0; repeat (4) step();
        chk("noupl_din", din, 8'hF6);
        chk("noupl_busy", busy, 0);

        // one write, three ticks -> one request, none on further ticks
        we_pulse();
        tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        session();

        // write coincident with 2nd tick restarts the count
        we_pulse();
        tick(1'b0, 1'b0); tick(1'b1, 1'b0);
        tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        session();

        // save_en=0 suppresses the pulse; tracking continues
        save_en = 1'b0;
        we_pulse();
        tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        repeat (5) step();
        save_en = 1'b1;
        req_q.push_back(cyc + 1);
        step(); step();
        session();

        // write during the session keeps dirty for another save
        we_pulse();
        tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        upload = 1'b1; step();
        do_read(25'd5, 8'hFA);
        cmos_we = 1'b1; step(); cmos_we = 1'b0;
        upload = 1'b0; step(); step();
        tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        session();

        // reset during WAIT
        upload = 1'b1; step();
        abort = 1'b1;
        rd = 1'b1; addr = 25'd5; step();
        rd = 1'b0; step();
        reset_n = 1'b0; step();
        chk("wrst_din", din, 8'h00);
        chk("wrst_ram_rd", ram_rd, 0);
        chk("wrst_ram_addr", ram_addr, 0);
        chk("wrst_busy", busy, 0);
        chk("wrst_upload_req", upload_req, 0);
        reset_n = 1'b1; step(); step();
        abort = 1'b0; step();
        do_read(25'h3FF, 8'hF3);
        upload = 1'b0;
        repeat (5) step();

        chk("din_q_left", din_q.size(), 0);
        chk("ram_q_left", ram_q_exp.size(), 0);
        chk("req_q_left", req_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
